irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the 5-stage pipeline processor; drives the processor's single `interupt` input.
- Latches rising edges on several peripheral request lines and applies a mask.
- Picks the highest-priority unmasked request and issues a fixed-length interrupt pulse plus a vector.
- Blocks further interrupts until the processor signals return-from-interrupt.

Parameters:
- NUM_SRC, 4, number of request sources (1..16).
- PULSE_CYCLES, 3, cycles `interupt` is held high per grant (>=1).
- VEC_BASE, 16'h0000, base vector; emitted vector = VEC_BASE + source index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  peripheral request lines, level; a rising edge raises a request.
- irq_mask  input  NUM_SRC  1 = source blocked from grant; its pending bit is still latched.
- rti  input  1  one-cycle pulse from processor on return-from-interrupt.
- interupt  output  1  interrupt line to processor.
- int_vector  output  16  vector of the granted source; stable from grant until the next grant.
- int_pending  output  NUM_SRC  current pending bits.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (asynchronous, all immediate): interupt=0, int_vector=VEC_BASE, int_pending=0, busy=0, state=IDLE, edge-detect history=0, pulse counter=0.
  - Reset mid-pulse drops interupt in the same instant.
- Edge detect:
  - irq_prev registers irq_src each cycle.
  - rise = irq_src & ~irq_prev; pending |= rise.
  - A source already high when reset deasserts produces one request, because history resets to 0.
- Grant set = pending & ~irq_mask. Priority: lowest index wins.
- FSM:
  - IDLE: if grant set is nonzero, latch the winning index, set int_vector = VEC_BASE + idx, clear that pending bit, load counter = PULSE_CYCLES-1, go to ASSERT.
  - ASSERT: interupt=1. If counter==0 go to IN_SERVICE, else decrement.
  - IN_SERVICE: interupt=0. Wait for rti=1, then go to IDLE.
  - rti in IDLE or ASSERT is ignored.
- Latency:
  - irq_src rises before edge k: pending bit set at edge k.
  - interupt rises at edge k+1 and stays high for exactly PULSE_CYCLES cycles.
  - Back-to-back: after rti sampled at edge m, state is IDLE; the next grant (if any) is taken at edge m+1.
- Simultaneous events:
  - A new rise on the source being cleared in the same cycle: set wins, and the request stays pending.
  - Multiple rises in the same cycle: all latch; they are served in priority order, one per rti.
  - Mask changes during ASSERT or IN_SERVICE do not affect the current grant.
- No nesting. Pending bits keep accumulating while busy; a repeated edge on an already-pending source is absorbed (no counting).
- Widths: the idx add wraps modulo 2^16.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_src passes through a 2-flop synchronizer (reset to 0) before edge detect. Edge-to-interupt latency grows by 2 cycles.
- Undefined: irq_src is assumed synchronous to clk and feeds edge detect directly.

Decomposition:
- Shared include `irq_ctrl_defs`: state encodings IDLE=2'b00, ASSERT=2'b01, IN_SERVICE=2'b10, and the default vector width 16.
- One natural sub-module, `irq_prio_enc`: combinational NUM_SRC-bit lowest-index-first encoder, outputs valid and idx.
- Counter, FSM and edge detect stay in the top level.

Test Plan:
1. Reset mid-ASSERT: assert reset between edges -> interupt=0 immediately, int_pending=0, busy=0; normal operation after release.
2. Single request: irq_src=4'b0100 rising before edge k, mask=0 -> int_pending[2]=1 after edge k; interupt=1 for edges k+1..k+3; int_vector=16'h0002; busy stays 1 until rti.
3. Priority: irq_src 0 -> 4'b1010 in one cycle -> first grant int_vector=1, int_pending=4'b1000. After rti, next grant int_vector=3.
4. Masking: irq_mask=4'b0001, edge on src0 -> no interupt, int_pending=4'b0001. Clear mask -> interupt rises 1 cycle later, vector=0.
5. Spurious rti in IDLE, and rti during ASSERT -> no state change; pulse length still 3.
6. IRQ_SYNC_EN defined, repeat scenario 2 -> interupt rises at edge k+3, same 3-cycle width.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings and widths.
package irq_ctrl_pkg;

  localparam int VEC_W = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_ASSERT     = 2'b01,
    ST_IN_SERVICE = 2'b10
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the grantable request set.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latching, maskable interrupt controller issuing a fixed-length pulse plus vector.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               NUM_SRC      = 4,
  parameter int               PULSE_CYCLES = 3,
  parameter logic [VEC_W-1:0] VEC_BASE     = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               rti,
  output logic               interupt,
  output logic [VEC_W-1:0]   int_vector,
  output logic [NUM_SRC-1:0] int_pending,
  output logic               busy
);

  localparam int               CNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] src_eff;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_eff = sync2_q;
`else
  assign src_eff = irq_src;
`endif

  // History resets to 0 so a line already high out of reset yields one request.
  assign rise = src_eff & ~prev_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req_i   (pend_q & ~irq_mask),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          vec_d   = VEC_BASE + VEC_W'(gnt_idx);
          clr     = NUM_SRC'(1) << gnt_idx;
          cnt_d   = CNT_LOAD;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) state_d = ST_IN_SERVICE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IN_SERVICE: begin
        if (rti) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh rise on the bit being granted this cycle keeps it pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= VEC_BASE;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
      prev_q  <= src_eff;
    end
  end

  assign interupt    = (state_q == ST_ASSERT);
  assign busy        = (state_q != ST_IDLE);
  assign int_vector  = vec_q;
  assign int_pending = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: grant-level reference model feeds an expectation queue.
module tb_irq_ctrl;

  localparam int          NS    = 4;
  localparam int          P     = 3;
  localparam logic [15:0] VBASE = 16'h0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_src;
  logic [NS-1:0] irq_mask;
  logic          rti;
  logic          interupt;
  logic [15:0]   int_vector;
  logic [NS-1:0] int_pending;
  logic          busy;

  irq_ctrl #(
    .NUM_SRC      (NS),
    .PULSE_CYCLES (P),
    .VEC_BASE     (VBASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .irq_mask    (irq_mask),
    .rti         (rti),
    .interupt    (interupt),
    .int_vector  (int_vector),
    .int_pending (int_pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        intr;
    logic [15:0] vec;
    logic [NS-1:0] pend;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t imm_q[$];
  event imm_ev;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tracks the pending set and the edge of the last grant.
  logic [NS-1:0] m_pend, m_prev, m_s1, m_s2;
  bit            m_wait;
  int            m_gedge;
  logic [15:0]   m_vec;
  int            e = 0;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    m_wait = 1'b0; m_gedge = -100; m_vec = VBASE;
  endtask

  task automatic model_edge();
    logic [NS-1:0] eff, gset;
    int idx;
    exp_t x;
    e++;
`ifdef IRQ_SYNC_EN
    eff  = m_s2;
    m_s2 = m_s1;
    m_s1 = irq_src;
`else
    eff = irq_src;
`endif
    if (m_wait) begin
      // rti only counts once the pulse has finished.
      if (rti && e > m_gedge + P) m_wait = 1'b0;
    end else begin
      gset = m_pend & ~irq_mask;
      idx  = -1;
      for (int i = NS - 1; i >= 0; i--) if (gset[i]) idx = i;
      if (idx >= 0) begin
        m_pend[idx] = 1'b0;
        m_vec       = VBASE + 16'(idx);
        m_wait      = 1'b1;
        m_gedge     = e;
      end
    end
    m_pend = m_pend | (eff & ~m_prev);
    m_prev = eff;
    x.tag  = e;
    x.intr = m_wait && (e >= m_gedge) && (e <= m_gedge + P - 1);
    x.vec  = m_vec;
    x.pend = m_pend;
    x.busy = m_wait;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare(input exp_t x);
    n_checks++;
    if (interupt !== x.intr) begin
      n_errors++;
      $display("FAIL interupt @%0d: got %b exp %b", x.tag, interupt, x.intr);
    end
    n_checks++;
    if (int_vector !== x.vec) begin
      n_errors++;
      $display("FAIL int_vector @%0d: got %h exp %h", x.tag, int_vector, x.vec);
    end
    n_checks++;
    if (int_pending !== x.pend) begin
      n_errors++;
      $display("FAIL int_pending @%0d: got %b exp %b", x.tag, int_pending, x.pend);
    end
    n_checks++;
    if (busy !== x.busy) begin
      n_errors++;
      $display("FAIL busy @%0d: got %b exp %b", x.tag, busy, x.busy);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or imm_ev);
      if (imm_q.size() != 0) compare(imm_q.pop_front());
      else if (exp_q.size() != 0) compare(exp_q.pop_front());
    end
  end

  task automatic pulse_rti();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  initial begin
    exp_t r;
    reset = 1'b1; irq_src = '0; irq_mask = '0; rti = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #7 reset = 1'b0;

    // Reset in the middle of a pulse, then release with a source still high.
    irq_src = 4'b0001;
    repeat (3) tick();
    #5;
    reset = 1'b1;
    #1;
    model_reset();
    r.tag = -1; r.intr = 1'b0; r.vec = VBASE; r.pend = '0; r.busy = 1'b0;
    imm_q.push_back(r);
    ->imm_ev;
    @(posedge clk);
    #7 reset = 1'b0;
    repeat (6) tick();
    irq_src = '0;
    pulse_rti();
    repeat (2) tick();

    // Single request on source 2.
    irq_src = 4'b0100;
    repeat (6) tick();
    irq_src = '0;
    pulse_rti();
    repeat (2) tick();

    // Two simultaneous rises served in priority order.
    irq_src = 4'b1010;
    repeat (6) tick();
    pulse_rti();
    repeat (6) tick();
    irq_src = '0;
    pulse_rti();
    repeat (2) tick();

    // Masked source latches but is not granted until unmasked.
    irq_mask = 4'b0001;
    irq_src  = 4'b0001;
    repeat (4) tick();
    irq_mask = 4'b0000;
    repeat (6) tick();
    irq_src = '0;

    // rti mid-pulse is ignored; rti in service completes; spurious rti in idle.
    irq_src = 4'b0010;
    repeat (2) tick();
    pulse_rti();
    repeat (3) tick();
    pulse_rti();
    pulse_rti();
    irq_src = '0;
    repeat (2) tick();

    // Re-rise on a source while it is granted keeps it pending.
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick();
    irq_src = 4'b0001;
    repeat (5) tick();
    pulse_rti();
    repeat (5) tick();
    pulse_rti();
    irq_src = '0;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_src = irq_src ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom) & 4'($urandom);
      rti = ($urandom_range(0, 5) == 0);
      tick();
    end
    rti = 1'b0;
    repeat (2) tick();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
